// File: rtl/bubble_stream_receiver_pkg.sv
// bubble_rx_pkg
// Shared definitions for the bubble stream receiver: FSM state encoding,
// the two-pair bootloader sync pattern, default capture lengths and the
// buffer address width.
// Optional feature macro used by the receiver: BUBBLE_RX_CHECKSUM_EN.
package bubble_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEEK_SYNC,
        ST_SYNC2,
        ST_SKIP,
        ST_CAPTURE,
        ST_DONE
    } rx_state_t;

    // Bootloader start pattern: one 01 pair immediately followed by 11
    localparam logic [1:0] SYNC_FIRST  = 2'b01;
    localparam logic [1:0] SYNC_SECOND = 2'b11;

    localparam int DEFAULT_BOOT_SEEK_MAX    = 2700;
    localparam int DEFAULT_BOOT_DATA_LENGTH = 1920;
    localparam int DEFAULT_PAGE_SKIP        = 100;
    localparam int DEFAULT_PAGE_DATA_LENGTH = 512;

    localparam int ADDR_WIDTH  = 11;
    localparam int COUNT_WIDTH = 16;

endpackage

// File: rtl/bubble_stream_receiver_if.sv
// bubble_stream_receiver_if
// Groups the bubble bus (strobe plus odd/even active-low data) with the
// 2048x2 buffer write port.
//   slave  : receiver side - samples the bubble bus, drives the write port
//   master : host/test side - drives the bubble bus, observes the write port
interface bubble_stream_receiver_if;
    import bubble_rx_pkg::*;

    logic                  data_out_strobe;
    logic                  bubble_in_odd;
    logic                  bubble_in_even;
    logic [ADDR_WIDTH-1:0] capture_write_address;
    logic [1:0]            capture_write_data;
    logic                  capture_write_enable;

    modport slave (
        input  data_out_strobe,
        input  bubble_in_odd,
        input  bubble_in_even,
        output capture_write_address,
        output capture_write_data,
        output capture_write_enable
    );

    modport master (
        output data_out_strobe,
        output bubble_in_odd,
        output bubble_in_even,
        input  capture_write_address,
        input  capture_write_data,
        input  capture_write_enable
    );

endinterface

// File: rtl/bubble_stream_receiver_strobe_sync.sv
// bubble_strobe_sync
// Brings the asynchronous bubble strobe and both data lines into the
// master_clock domain through 2-FF synchronizers and produces a one-cycle
// pulse on each rising edge of the synchronized strobe.
// Ports:
//   master_clock, reset          : clock, async active-high reset
//   strobe_async                 : raw data-out strobe
//   odd_async, even_async        : raw active-low data lines
//   sample_event                 : one-cycle pulse per strobe rising edge
//   sample_pair                  : de-inverted {odd, even}, valid with sample_event
module bubble_strobe_sync (
    input  logic       master_clock,
    input  logic       reset,
    input  logic       strobe_async,
    input  logic       odd_async,
    input  logic       even_async,
    output logic       sample_event,
    output logic [1:0] sample_pair
);

    logic [2:0] strobe_pipe;
    logic [1:0] odd_pipe;
    logic [1:0] even_pipe;

    // Data lines reset to their idle (high) level so a spurious event right
    // after reset reads as 00 rather than 11.
    always_ff @(posedge master_clock or posedge reset) begin
        if (reset) begin
            strobe_pipe <= '0;
            odd_pipe    <= '1;
            even_pipe   <= '1;
        end else begin
            strobe_pipe <= {strobe_pipe[1:0], strobe_async};
            odd_pipe    <= {odd_pipe[0], odd_async};
            even_pipe   <= {even_pipe[0], even_async};
        end
    end

    // Data is stable around the strobe rising edge, so the synchronized data
    // stage lines up with the synchronized strobe stage.
    assign sample_event = strobe_pipe[1] & ~strobe_pipe[2];
    assign sample_pair  = ~{odd_pipe[1], even_pipe[1]};

endmodule

// File: rtl/bubble_stream_receiver.sv
// bubble_stream_receiver
// Captures the two-channel bubble data stream into a 2048x2 buffer.
// Bootloader mode hunts for the 01,11 start pattern (with a timeout);
// page mode discards a fixed number of leading pairs. Each captured pair is
// written de-inverted with an active-low one-cycle write enable.
// Optional feature: define BUBBLE_RX_CHECKSUM_EN to get a running 16-bit
// sum of written pairs on capture_checksum; otherwise it is tied to zero.
// Ports:
//   master_clock, reset      : clock, async active-high reset
//   capture_start            : one-cycle pulse arming a capture (IDLE only)
//   capture_mode             : 1 = bootloader, 0 = page (sampled on start)
//   bus                      : bubble bus in, buffer write port out
//   capture_busy             : high while a capture is in progress
//   capture_done             : one-cycle completion pulse
//   capture_error            : sticky seek timeout flag
//   capture_checksum         : running payload sum
module bubble_stream_receiver
    import bubble_rx_pkg::*;
#(
    parameter int BOOT_SEEK_MAX    = DEFAULT_BOOT_SEEK_MAX,
    parameter int BOOT_DATA_LENGTH = DEFAULT_BOOT_DATA_LENGTH,
    parameter int PAGE_SKIP        = DEFAULT_PAGE_SKIP,
    parameter int PAGE_DATA_LENGTH = DEFAULT_PAGE_DATA_LENGTH
) (
    input  logic                      master_clock,
    input  logic                      reset,
    input  logic                      capture_start,
    input  logic                      capture_mode,
    bubble_stream_receiver_if.slave   bus,
    output logic                      capture_busy,
    output logic                      capture_done,
    output logic                      capture_error,
    output logic [15:0]               capture_checksum
);

    localparam logic [COUNT_WIDTH-1:0] SEEK_LAST = COUNT_WIDTH'(BOOT_SEEK_MAX - 1);
    localparam logic [COUNT_WIDTH-1:0] SKIP_LAST = COUNT_WIDTH'(PAGE_SKIP - 1);
    localparam logic [COUNT_WIDTH-1:0] BOOT_LAST = COUNT_WIDTH'(BOOT_DATA_LENGTH - 1);
    localparam logic [COUNT_WIDTH-1:0] PAGE_LAST = COUNT_WIDTH'(PAGE_DATA_LENGTH - 1);

    rx_state_t state;
    rx_state_t next_state;

    logic                   sample_event;
    logic [1:0]             sample_pair;
    logic                   mode_boot;
    logic [COUNT_WIDTH-1:0] seek_count;
    logic [COUNT_WIDTH-1:0] skip_count;
    logic [COUNT_WIDTH-1:0] write_count;
    logic [COUNT_WIDTH-1:0] capture_last;
    logic [ADDR_WIDTH-1:0]  write_address;
    logic [1:0]             write_data;
    logic                   write_enable_n;

    logic start_accept;
    logic seek_inc;
    logic skip_inc;
    logic do_write;
    logic timeout_hit;

    bubble_strobe_sync u_sync (
        .master_clock (master_clock),
        .reset        (reset),
        .strobe_async (bus.data_out_strobe),
        .odd_async    (bus.bubble_in_odd),
        .even_async   (bus.bubble_in_even),
        .sample_event (sample_event),
        .sample_pair  (sample_pair)
    );

    assign capture_last = mode_boot ? BOOT_LAST : PAGE_LAST;

    // State register
    always_ff @(posedge master_clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and datapath control. The seek counter counts every non-01
    // pair seen before sync completes, including pairs that knock SYNC2 back
    // to SEEK_SYNC; a 01 while in SYNC2 just extends the preamble.
    always_comb begin
        next_state   = state;
        start_accept = 1'b0;
        seek_inc     = 1'b0;
        skip_inc     = 1'b0;
        do_write     = 1'b0;
        timeout_hit  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (capture_start) begin
                    start_accept = 1'b1;
                    if (capture_mode) begin
                        next_state = ST_SEEK_SYNC;
                    end else if (PAGE_SKIP == 0) begin
                        next_state = ST_CAPTURE;
                    end else begin
                        next_state = ST_SKIP;
                    end
                end
            end
            ST_SEEK_SYNC: begin
                if (sample_event) begin
                    if (sample_pair == SYNC_FIRST) begin
                        next_state = ST_SYNC2;
                    end else if (seek_count == SEEK_LAST) begin
                        timeout_hit = 1'b1;
                        next_state  = ST_DONE;
                    end else begin
                        seek_inc = 1'b1;
                    end
                end
            end
            ST_SYNC2: begin
                if (sample_event) begin
                    if (sample_pair == SYNC_SECOND) begin
                        next_state = ST_CAPTURE;
                    end else if (sample_pair != SYNC_FIRST) begin
                        if (seek_count == SEEK_LAST) begin
                            timeout_hit = 1'b1;
                            next_state  = ST_DONE;
                        end else begin
                            seek_inc   = 1'b1;
                            next_state = ST_SEEK_SYNC;
                        end
                    end
                end
            end
            ST_SKIP: begin
                if (sample_event) begin
                    if (skip_count == SKIP_LAST) begin
                        next_state = ST_CAPTURE;
                    end else begin
                        skip_inc = 1'b1;
                    end
                end
            end
            ST_CAPTURE: begin
                if (sample_event) begin
                    do_write = 1'b1;
                    if (write_count == capture_last) begin
                        next_state = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Counters, registered write port and status flags. The done pulse is
    // registered from the DONE state so it lands one cycle after the final
    // write, the same cycle busy drops.
    always_ff @(posedge master_clock or posedge reset) begin
        if (reset) begin
            mode_boot      <= 1'b0;
            seek_count     <= '0;
            skip_count     <= '0;
            write_count    <= '0;
            write_address  <= '0;
            write_data     <= 2'b00;
            write_enable_n <= 1'b1;
            capture_done   <= 1'b0;
            capture_error  <= 1'b0;
        end else begin
            capture_done   <= (state == ST_DONE);
            write_enable_n <= 1'b1;
            if (start_accept) begin
                mode_boot     <= capture_mode;
                seek_count    <= '0;
                skip_count    <= '0;
                write_count   <= '0;
                write_address <= '0;
                capture_error <= 1'b0;
            end
            if (seek_inc) begin
                seek_count <= seek_count + 1'b1;
            end
            if (skip_inc) begin
                skip_count <= skip_count + 1'b1;
            end
            if (timeout_hit) begin
                capture_error <= 1'b1;
            end
            if (do_write) begin
                write_enable_n <= 1'b0;
                write_address  <= write_count[ADDR_WIDTH-1:0];
                write_data     <= sample_pair;
                write_count    <= write_count + 1'b1;
            end
        end
    end

`ifdef BUBBLE_RX_CHECKSUM_EN
    // Accumulates the pair presented on the write port during its write cycle
    always_ff @(posedge master_clock or posedge reset) begin
        if (reset) begin
            capture_checksum <= '0;
        end else if (start_accept) begin
            capture_checksum <= '0;
        end else if (!write_enable_n) begin
            capture_checksum <= capture_checksum + {14'b0, write_data};
        end
    end
`else
    assign capture_checksum = '0;
`endif

    assign capture_busy              = (state != ST_IDLE);
    assign bus.capture_write_address = write_address;
    assign bus.capture_write_data    = write_data;
    assign bus.capture_write_enable  = write_enable_n;

endmodule

// File: doc/bubble_stream_receiver.md
# bubble_stream_receiver

Capture-side counterpart of the bubble output interface: samples the active-low two-channel bubble data stream (odd/even) on the data-out strobe, locates the payload (bootloader via start pattern, page via fixed bit offset) and writes de-inverted bit pairs into a 2048×2 buffer using the same write-port shape as the SPI loader. It sits on the host/test side of the bubble bus, in the master_clock domain, and is used for loopback verification and page readback.

## Interface
Parameters:
- BOOT_SEEK_MAX, 2700: strobes allowed in SEEK_SYNC before timeout
- BOOT_DATA_LENGTH, 1920: bit pairs captured after bootloader start pattern
- PAGE_SKIP, 100: leading page strobes discarded
- PAGE_DATA_LENGTH, 512: bit pairs captured per page
- Constraint: both data lengths ≤ 2048

Ports (one clock; reset is asynchronous and active-high):
- master_clock  in  1  48 MHz master clock
- reset  in  1  asynchronous, active-high
- capture_start  in  1  one-cycle pulse, arms a capture
- capture_mode  in  1  1 = bootloader, 0 = page; sampled on capture_start
- data_out_strobe  in  1  asynchronous bubble strobe
- bubble_in_odd  in  1  active-low data, odd channel
- bubble_in_even  in  1  active-low data, even channel
- capture_write_address  out  11  buffer write address
- capture_write_data  out  2  {odd, even}, de-inverted
- capture_write_enable  out  1  active low, one cycle per pair
- capture_busy  out  1  high from IDLE exit until DONE
- capture_done  out  1  one-cycle pulse at completion
- capture_error  out  1  sticky timeout flag, cleared by next capture_start
- capture_checksum  out  16  running payload sum (see Configuration)

## Operation
- Strobe and both data lines pass through 2-FF synchronizers; rising edge of synchronized strobe = sample event (data changes on falling edge, stable at rising edge).
- Stored pair = ~{bubble_in_odd, bubble_in_even}; idle lines (both high) store 00.
- States: IDLE, SEEK_SYNC, SYNC2, SKIP, CAPTURE, DONE.
- IDLE: capture_start → SEEK_SYNC (mode 1) or SKIP (mode 0); clear address, counters, error, checksum.
- SEEK_SYNC: pair 01 → SYNC2; else count; count reaching BOOT_SEEK_MAX → set capture_error, go DONE.
- SYNC2: pair 11 → CAPTURE; pair 01 → stay SYNC2; other → SEEK_SYNC. Seek counter keeps running in SYNC2.
- SKIP: discard PAGE_SKIP sample events, then CAPTURE.
- CAPTURE: each event writes pair at current address, then address +1; after BOOT_DATA_LENGTH or PAGE_DATA_LENGTH writes → DONE.
- DONE: pulse capture_done one cycle, → IDLE.
- capture_start outside IDLE ignored. Address never wraps (length constraint).

## Timing
- Reset values: address 0, data 00, write_enable 1, busy 0, done 0, error 0, checksum 0, state IDLE.
- Latency: strobe rising edge at pin → capture_write_enable low for exactly one cycle, 3 master_clock cycles later (2 sync + 1 register); address/data valid in that same cycle.
- capture_done asserts on the cycle after the last write; busy falls in that same cycle.
- Strobe high/low each ≥ 3 master_clock cycles; shorter pulses are undefined.
- Reset asserted mid-capture: immediate return to reset values; partial buffer contents not invalidated.
- capture_start coincident with final write: ignored.

## Configuration
- BUBBLE_RX_CHECKSUM_EN defined: capture_checksum = 16-bit wrap-around sum of all written 2-bit pairs (zero-extended), updated the cycle after each write, cleared on capture_start.
- Not defined: capture_checksum tied to 0; no adder logic.

## Structure
- Package bubble_rx_pkg: state encoding, sync pattern constants (2'b01, 2'b11), default length constants.
- Sub-module bubble_strobe_sync: 2-FF synchronizers for strobe and data, rising-edge pulse output.

## Test plan
- Bootloader: 2640 idle pairs, 01, 11, 1920 pairs equal to index[1:0] → 1920 writes, addr 0..1919, data index[1:0], one done pulse, error 0.
- Page: capture_mode 0, 703 strobes, pair k = k[1:0] → first write carries pair 101, 512 writes, done after write 511.
- False sync: 01, 10, then 01, 01, 11 → capture begins only after the final 11.
- Timeout: 2700 idle strobes → capture_error 1, done pulse, zero writes.
- Reset after 300 captured pairs → all outputs at reset values next cycle; new capture restarts at address 0.
- With BUBBLE_RX_CHECKSUM_EN: 512 pairs all 11 → capture_checksum = 1536.
